// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_queue_pkg                                                        |
// | Shared fetch constants: reset PC, NOP encoding, word-align bits.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package fetch_queue_pkg;

  localparam logic [31:0] c_reset_pc   = 32'h0040_0000;
  localparam logic [31:0] c_nop        = 32'h0000_0000;
  localparam logic [31:0] c_align_bits = 32'h0000_0003;

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_queue_if                                                         |
// | Instruction-memory read port plus decode valid/ready handshake.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);

  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output imem_en, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rdata, inst_ready
  );

  modport slave (
    input  imem_en, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rdata, inst_ready
  );

endinterface : fetch_queue_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_fifo                                                             |
// | Circular DEPTH-entry queue with flush; head holds its last value       |
// | while empty. Revision: 1.0                                             |
// +------------------------------------------------------------------------+
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;
  assign count = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    hold_d   = head;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_queue                                                            |
// | PC owner, credit-limited imem reader and decode queue with redirect.   |
// | Option macro FETCH_HALT_ON_ZERO_EN: zero word stops fetch.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(c_reset_pc)
) (
  input  logic              clock,
  input  logic              reset_n,
  fetch_queue_if.master     bus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int SUM_W  = PTR_W + 2;
  localparam int FIFO_W = INST_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              halted_q, halted_d;
  logic              run_q;

  logic              handshake;
  logic              pop;
  logic              push;
  logic              issue;
  logic              halt_now;
  logic              credit_ok;
  logic [SUM_W-1:0]  occupancy;
  logic [PTR_W:0]    count;
  logic [FIFO_W-1:0] head;

  always_comb begin
    handshake = bus.inst_valid && bus.inst_ready;
    pop       = handshake && !redirect_valid;
    // Queued words plus the one read in flight must leave room after this pop.
    occupancy = SUM_W'(count) + SUM_W'(inflight_q);
    credit_ok = occupancy < (SUM_W'(DEPTH) + SUM_W'(handshake));
`ifdef FETCH_HALT_ON_ZERO_EN
    halt_now  = inflight_q && !halted_q && (bus.imem_rdata == INST_W'(c_nop));
`else
    halt_now  = 1'b0;
`endif
    issue     = run_q && !redirect_valid && !halted_q && !halt_now && credit_ok;
    push      = inflight_q && !redirect_valid && !halted_q && !halt_now;

    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
    halted_d      = redirect_valid ? 1'b0 : (halted_q || halt_now);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~ADDR_W'(c_align_bits);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({bus.imem_rdata, inflight_pc_q}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_en    = issue;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = head[FIFO_W-1:ADDR_W];
  assign bus.inst_pc    = head[ADDR_W-1:0];
  assign halted         = halted_q;

  // run_q keeps imem_en low while reset is held and for the first edge after.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      halted_q      <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      halted_q      <= halted_d;
      run_q         <= 1'b1;
    end
  end

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fetch_queue                                                         |
// | Table vectors, directed corner sequences and a random scoreboard run.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

  fetch_queue #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0040_0000)
  ) u_dut (
    .clock          (clk),
    .reset_n        (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  logic [31:0] ovr [logic [31:0]];

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return ((a - 32'h0040_0000) >> 2) + 32'd1;
  endfunction

  always @(posedge clk) begin
    if (bus.imem_en === 1'b1) bus.imem_rdata <= memword(bus.imem_addr);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got [$];
    logic        found;
    logic        acc;
    logic        prev_hold;
    logic [31:0] prev_d, prev_p, exp_pc;
    int          occ;
    int          accepts;

    rst_n          = 1'b0;
    bus.inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ovr[32'h0050_0000] = 32'h0000_0011;
    ovr[32'h0050_0004] = 32'h0000_0022;
    ovr[32'h0050_0008] = 32'h0000_0000;

    // Cycle-exact start-up and back-pressure trace, step 0 = cycle before first edge.
    tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'h0040_0000, 1'b0, 32'h0,         32'd0};
    tbl[2]  = '{1'b1, 1'b1, 32'h0040_0004, 1'b0, 32'h0,         32'd0};
    tbl[3]  = '{1'b1, 1'b1, 32'h0040_0008, 1'b1, 32'h0040_0000, 32'd1};
    tbl[4]  = '{1'b1, 1'b1, 32'h0040_000c, 1'b1, 32'h0040_0004, 32'd2};
    tbl[5]  = '{1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0008, 32'd3};
    tbl[6]  = '{1'b0, 1'b1, 32'h0040_0014, 1'b1, 32'h0040_000c, 32'd4};
    tbl[7]  = '{1'b0, 1'b1, 32'h0040_0018, 1'b1, 32'h0040_000c, 32'd4};
    for (int i = 8; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_000c, 32'd4};
    tbl[16] = '{1'b1, 1'b1, 32'h0040_001c, 1'b1, 32'h0040_000c, 32'd4};
    tbl[17] = '{1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0010, 32'd5};
    tbl[18] = '{1'b1, 1'b1, 32'h0040_0024, 1'b1, 32'h0040_0014, 32'd6};
    tbl[19] = '{1'b1, 1'b1, 32'h0040_0028, 1'b1, 32'h0040_0018, 32'd7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.imem_en", bus.imem_en, 0);
    chk("reset.inst_valid", bus.inst_valid, 0);
    chk("reset.inst_data", bus.inst_data, 0);
    chk("reset.inst_pc", bus.inst_pc, 0);
    chk("reset.halted", halted, 0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      bus.inst_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d.en", i), bus.imem_en, tbl[i].en);
      if (tbl[i].en) chk($sformatf("tbl%0d.addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d.valid", i), bus.inst_valid, tbl[i].vld);
      chk($sformatf("tbl%0d.pc", i), bus.inst_pc, tbl[i].pc);
      chk($sformatf("tbl%0d.data", i), bus.inst_data, tbl[i].data);
      tick();
    end

    // Redirect while a response is in flight and the head is being accepted.
    bus.inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0043;
    @(negedge clk);
    chk("redir.no_issue", bus.imem_en, 0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir.empty", bus.inst_valid, 0);
    chk("redir.en1", bus.imem_en, 1);
    chk("redir.addr1", bus.imem_addr, 32'h0040_0040);
    tick();
    @(negedge clk);
    chk("redir.still_empty", bus.inst_valid, 0);
    chk("redir.addr2", bus.imem_addr, 32'h0040_0044);
    tick();
    @(negedge clk);
    chk("redir.valid", bus.inst_valid, 1);
    chk("redir.pc", bus.inst_pc, 32'h0040_0040);
    chk("redir.data", bus.inst_data, 32'd17);
    tick();

    // Zero word in the stream.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0050_0000;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.inst_valid && bus.inst_ready) got.push_back(bus.inst_data);
      tick();
    end
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("halt.count", got.size(), 2);
    while (got.size() < 3) got.push_back(32'hDEAD_BEEF);
    chk("halt.w0", got[0], 32'h11);
    chk("halt.w1", got[1], 32'h22);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("halt.halted", halted, 1);
      chk("halt.en_low", bus.imem_en, 0);
      chk("halt.drained", bus.inst_valid, 0);
      tick();
    end
`else
    chk("nohalt.count_ge3", got.size() >= 3, 1);
    while (got.size() < 3) got.push_back(32'hDEAD_BEEF);
    chk("nohalt.w0", got[0], 32'h11);
    chk("nohalt.w1", got[1], 32'h22);
    chk("nohalt.w2", got[2], 32'h0);
    @(negedge clk);
    chk("nohalt.halted", halted, 0);
    tick();
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0000;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("resume.halted", halted, 0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.inst_valid) found = 1'b1;
      else tick();
    end
    chk("resume.found", found, 1);
    chk("resume.pc", bus.inst_pc, 32'h0040_0000);
    chk("resume.data", bus.inst_data, 32'd1);
    tick();
    repeat (3) tick();

    // Asynchronous reset pulse away from the clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset.en", bus.imem_en, 0);
    chk("areset.valid", bus.inst_valid, 0);
    chk("areset.data", bus.inst_data, 0);
    chk("areset.pc", bus.inst_pc, 0);
    chk("areset.halted", halted, 0);
    tick();
    rst_n = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.imem_en) found = 1'b1;
      else tick();
    end
    chk("areset.found", found, 1);
    chk("areset.addr", bus.imem_addr, 32'h0040_0000);
    tick();

    // Random traffic against an occupancy / expected-PC model.
    occ       = 0;
    accepts   = 0;
    exp_pc    = '0;
    prev_hold = 1'b0;
    prev_d    = '0;
    prev_p    = '0;
    for (int c = 0; c < 2000; c++) begin
      bus.inst_ready = ($urandom_range(3) != 0);
      redirect_valid = (c == 0) || ($urandom_range(31) == 0);
      redirect_pc    = 32'h0040_0000 + 32'($urandom_range(1023));
      @(negedge clk);
      acc = bus.inst_valid && bus.inst_ready && !redirect_valid;
      if (c > 0) begin
        if (prev_hold) begin
          chk("rnd.hold_valid", bus.inst_valid, 1);
          chk("rnd.hold_data", bus.inst_data, prev_d);
          chk("rnd.hold_pc", bus.inst_pc, prev_p);
        end
        chk("rnd.en", bus.imem_en, (!redirect_valid && ((occ - int'(acc)) < DEPTH)));
        if (bus.imem_en) chk("rnd.align", bus.imem_addr[1:0], 0);
        if (acc) begin
          chk("rnd.pc", bus.inst_pc, exp_pc);
          chk("rnd.data", bus.inst_data, memword(exp_pc));
          exp_pc = exp_pc + 32'd4;
          accepts++;
        end
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        occ    = 0;
      end else begin
        occ = occ + int'(bus.imem_en) - int'(acc);
      end
      prev_hold = bus.inst_valid && !bus.inst_ready && !redirect_valid;
      prev_d    = bus.inst_data;
      prev_p    = bus.inst_pc;
      tick();
    end
    chk("rnd.progress", accepts > 500, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fetch_queue
`default_nettype wire
